// File: rtl/keypad_matrix_scanner.sv
// Row-scanning keypad controller: drives one-cold rows, samples active-low columns,
// debounces whole-frame results and reports single-key press/release and multi-key frames.
module keypad_matrix_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 3,
  parameter int CODE_W   = 4
) (
  input  logic              clk_div,
  input  logic              reset,
  input  logic [COLS-1:0]   keypad_col,
  output logic [ROWS-1:0]   keypad_row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_press,
  output logic              key_release,
  output logic              multi_key
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int SW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  typedef enum logic [1:0] {
    CAND_NONE  = 2'd0,
    CAND_KEY   = 2'd1,
    CAND_MULTI = 2'd2
  } cand_e;

  typedef enum logic {
    ACC_NONE = 1'b0,
    ACC_KEY  = 1'b1
  } acc_e;

  logic [DW-1:0]     dwell_q, dwell_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic [ROWS-1:0]   row_drv_q, row_drv_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] first_q, first_d;
  cand_e             prev_kind_q, prev_kind_d;
  logic [CODE_W-1:0] prev_code_q, prev_code_d;
  logic [SW-1:0]     stab_q, stab_d;
  logic              eval_q, eval_d;
  acc_e              acc_q, acc_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              multi_q, multi_d;

  logic              sample_s;
  logic              frame_end_s;
  logic [1:0]        frame_cnt_s;
  logic [CODE_W-1:0] frame_code_s;
  cand_e             cand_s;
  logic              same_s;
  logic              differs_s;
  logic              take_s;

  function automatic logic [CODE_W-1:0] key_index(input logic [RW-1:0] row, input int col);
    key_index = CODE_W'(int'(row) * COLS + col);
  endfunction

  assign sample_s    = (dwell_q == DW'(SETTLE));
  assign frame_end_s = sample_s && (row_idx_q == RW'(ROWS - 1));

  // Fold the current row's sample into the running frame totals (count saturates at 2)
  always_comb begin
    frame_cnt_s  = cnt_q;
    frame_code_s = first_q;
    for (int c = 0; c < COLS; c++) begin
      frame_code_s = (sample_s && !keypad_col[c] && (frame_cnt_s == 2'd0)) ?
                     key_index(row_idx_q, c) : frame_code_s;
      frame_cnt_s  = (sample_s && !keypad_col[c] && (frame_cnt_s != 2'd2)) ?
                     frame_cnt_s + 2'd1 : frame_cnt_s;
    end
  end

  always_comb begin
    case (frame_cnt_s)
      2'd0:    cand_s = CAND_NONE;
      2'd1:    cand_s = CAND_KEY;
      default: cand_s = CAND_MULTI;
    endcase
  end

  // Row dwell timing and one-cold rotation; accumulators restart with each new frame
  always_comb begin
    dwell_d   = dwell_q;
    row_idx_d = row_idx_q;
    row_drv_d = row_drv_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    if (sample_s) begin
      dwell_d   = '0;
      row_drv_d = {row_drv_q[ROWS-2:0], row_drv_q[ROWS-1]};
      if (frame_end_s) begin
        row_idx_d = '0;
        cnt_d     = 2'd0;
        first_d   = '0;
      end else begin
        row_idx_d = row_idx_q + RW'(1);
        cnt_d     = frame_cnt_s;
        first_d   = frame_code_s;
      end
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  assign same_s = (cand_s == prev_kind_q) &&
                  ((cand_s != CAND_KEY) || (frame_code_s == prev_code_q));

  // Frame-end stability tracking; a MULTI frame poisons the previous candidate
  always_comb begin
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    stab_d      = stab_q;
    eval_d      = 1'b0;
    multi_d     = multi_q;
    if (frame_end_s) begin
      if (cand_s == CAND_MULTI) begin
        prev_kind_d = CAND_MULTI;
        stab_d      = '0;
        multi_d     = 1'b1;
      end else begin
        prev_kind_d = cand_s;
        prev_code_d = frame_code_s;
        multi_d     = 1'b0;
        eval_d      = 1'b1;
        if (!same_s) begin
          stab_d = SW'(1);
        end else if (stab_q != SW'(DEBOUNCE)) begin
          stab_d = stab_q + SW'(1);
        end else begin
          stab_d = stab_q;
        end
      end
    end else begin
      eval_d = 1'b0;
    end
  end

  always_comb begin
    case (prev_kind_q)
      CAND_NONE: differs_s = (acc_q == ACC_KEY);
      CAND_KEY:  differs_s = (acc_q == ACC_NONE) || (acc_code_q != prev_code_q);
      default:   differs_s = 1'b0;
    endcase
  end

  // Acceptance is decided the cycle after a frame end, from the registered candidate
  assign take_s = eval_q && (stab_q == SW'(DEBOUNCE)) && differs_s;

  // Accepted-state FSM and output next-state
  always_comb begin
    acc_d      = acc_q;
    acc_code_d = acc_code_q;
    code_d     = code_q;
    valid_d    = valid_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    case (acc_q)
      ACC_NONE: begin
        if (take_s) begin
          acc_d      = ACC_KEY;
          acc_code_d = prev_code_q;
          code_d     = prev_code_q;
          valid_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          acc_d = ACC_NONE;
        end
      end
      ACC_KEY: begin
        if (take_s && (prev_kind_q == CAND_NONE)) begin
          acc_d     = ACC_NONE;
          valid_d   = 1'b0;
          release_d = 1'b1;
        end else if (take_s) begin
          acc_code_d = prev_code_q;
          code_d     = prev_code_q;
          press_d    = 1'b1;
        end else begin
          acc_d = ACC_KEY;
        end
      end
      default: begin
        acc_d   = ACC_NONE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      dwell_q     <= '0;
      row_idx_q   <= '0;
      row_drv_q   <= {{(ROWS-1){1'b1}}, 1'b0};
      cnt_q       <= 2'd0;
      first_q     <= '0;
      prev_kind_q <= CAND_NONE;
      prev_code_q <= '0;
      stab_q      <= '0;
      eval_q      <= 1'b0;
      acc_q       <= ACC_NONE;
      acc_code_q  <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      row_drv_q   <= row_drv_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      stab_q      <= stab_d;
      eval_q      <= eval_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
      multi_q     <= multi_d;
    end
  end

  assign keypad_row  = row_drv_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign multi_key   = multi_q;

endmodule
